sd_seq_ctrl: RTL and testbench
==============================

SD_SEQ_CTRL -- requirements
Module: sd_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, 32, width of block address bus.
REQ-002 Parameter DATA_W, 32, width of read data word.
REQ-003 Parameter BASE_ADDR, 32'h0000_0200, address of block 0.
REQ-004 Parameter BLK_SHIFT, 9, log2 of block stride in address units (512).
REQ-005 Parameter CNT_W, 8, width of block count.
REQ-006 Parameter TIMEOUT, 65535, max CLK cycles waiting on any done.
REQ-007 Parameter MAX_RETRY, 3, attempts allowed per phase after first failure.
REQ-008 Ports (name  direction  width  meaning):
- CLK  in  1  sole clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  start request, sampled only in IDLE.
- reinit  in  1  force INIT on next go even if card already initialised.
- blk_offset  in  16  first block index.
- blk_count  in  CNT_W  blocks to read; 0 means 2^CNT_W.
- init_start  out  1  level request to initialiser.
- init_done  in  1  initialiser completion.
- read_start  out  1  level request to block reader.
- read_done  in  1  reader completion.
- rd_addr  out  ADDR_W  address presented to reader.
- rd_data  in  DATA_W  reader result word.
- data_out  out  DATA_W  captured word.
- data_valid  out  1  one-cycle pulse, data_out valid.
- busy  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky fault flag, cleared by next accepted go.
- state_dbg  out  4  encoded current state.

Function
REQ-009 States/encodings: IDLE=0, INIT=1, READ=2, GAP=3, FIN=4, ERR=5; all others decode to IDLE next cycle.
REQ-010 IDLE + go: latch blk_offset/blk_count, clear index, retry count, error; go to INIT if init_ok=0 or reinit=1, else READ.
REQ-011 init_start SHALL be 1 exactly while in INIT; read_start exactly while in READ; both registered-state decoded, no glitches.
REQ-012 INIT + init_done: set init_ok, clear retry and timer, go to READ.
REQ-013 READ + read_done: capture rd_data into data_out, pulse data_valid next cycle, increment index; go to FIN if index reaches count, else GAP.
REQ-014 GAP lasts exactly 1 cycle with both starts low, then READ (forces start re-edge per block).
REQ-015 rd_addr = BASE_ADDR + ((blk_offset + index) << BLK_SHIFT), truncated modulo 2^ADDR_W (wrap permitted, no error).
REQ-016 Timer clears on entering INIT/READ, increments each cycle there; reaching TIMEOUT with no done is a failure.
REQ-017 Failure with retry < MAX_RETRY: retry+1, go to GAP, then re-enter same phase (INIT retries to INIT, clearing init_ok); otherwise go to ERR.
REQ-018 ERR: error=1, init_ok=0, done_o not pulsed; returns to IDLE next cycle, error held.
REQ-019 FIN: done_o pulse one cycle, then IDLE.
REQ-020 done arriving same cycle as timeout expiry counts as success.
REQ-021 go while busy ignored; init_done/read_done outside their states ignored.
REQ-022 Retry count resets per block after each successful read.

Reset
REQ-023 reset asynchronously forces IDLE, init_ok=0, index=0, retry=0, timer=0, data_out=0, rd_addr=BASE_ADDR, all strobes/flags 0.
REQ-024 reset mid-transfer aborts immediately; no done_o/data_valid emitted afterwards until new go.

Verification
REQ-025 Fresh reset, go, blk_offset=0, count=1, init_done after 10 cycles, read_done with rd_data=32'hDEADBEEF -> rd_addr=0x200, data_valid once, data_out=DEADBEEF, done_o one pulse.
REQ-026 Second go, reinit=0, offset=3, count=2 -> INIT skipped, rd_addr 0x800 then 0xA00, GAP cycle with read_start low between.
REQ-027 init_done never asserted, TIMEOUT=16 -> 4 INIT attempts, each with 1-cycle gap, then ERR, error=1, busy=0.
REQ-028 offset=16'hFFFF, ADDR_W=24, BLK_SHIFT=9 -> address wraps modulo 2^24, no error.
REQ-029 reset asserted during READ -> outputs return to reset values same cycle, late read_done ignored.

Source files
------------

// File: rtl/sd_seq_ctrl.sv
// sd_seq_ctrl: sequences SD card init then a run of block reads, with per-phase timeout and retry.
module sd_seq_ctrl #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0200,
  parameter int          BLK_SHIFT = 9,
  parameter int          CNT_W     = 8,
  parameter int          TIMEOUT   = 65535,
  parameter int          MAX_RETRY = 3
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              go,
  input  logic              reinit,
  input  logic [15:0]       blk_offset,
  input  logic [CNT_W-1:0]  blk_count,
  output logic              init_start,
  input  logic              init_done,
  output logic              read_start,
  input  logic              read_done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              done_o,
  output logic              error,
  output logic [3:0]        state_dbg
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  typedef enum logic [3:0] {IDLE = 4'd0, INIT = 4'd1, READ = 4'd2, GAP = 4'd3, FIN = 4'd4, ERR = 4'd5} state_t;

  state_t            state_q, state_d;
  logic              init_ok_q, init_ok_d;
  logic              redo_init_q, redo_init_d;
  logic [15:0]       off_q, off_d;
  logic [CNT_W:0]    cnt_q, cnt_d, idx_q, idx_d, idx_inc;
  logic [RW-1:0]     retry_q, retry_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d, err_q, err_d;
  logic              fail, can_retry;

  assign idx_inc    = idx_q + 1'b1;
  assign can_retry  = retry_q < R_MAX;
  assign init_start = state_q == INIT;
  assign read_start = state_q == READ;
  assign busy       = state_q != IDLE;
  assign done_o     = state_q == FIN;
  assign state_dbg  = state_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign error      = err_q;
  // Arithmetic is done at ADDR_W so any overflow simply wraps.
  assign rd_addr    = ADDR_W'(BASE_ADDR) + ((ADDR_W'(off_q) + ADDR_W'(idx_q)) << BLK_SHIFT);

  always_comb begin
    state_d     = state_q;
    init_ok_d   = init_ok_q;
    redo_init_d = redo_init_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    err_d       = err_q;
    fail        = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        off_d       = blk_offset;
        cnt_d       = blk_count == '0 ? {1'b1, {CNT_W{1'b0}}} : {1'b0, blk_count};
        idx_d       = '0;
        retry_d     = '0;
        err_d       = 1'b0;
        redo_init_d = 1'b0;
        state_d     = (!init_ok_q || reinit) ? INIT : READ;
      end
      INIT: if (init_done) begin
        init_ok_d   = 1'b1;
        redo_init_d = 1'b0;
        retry_d     = '0;
        state_d     = READ;
      end else fail = timer_q == T_LAST;
      READ: if (read_done) begin
        data_d  = rd_data;
        valid_d = 1'b1;
        idx_d   = idx_inc;
        retry_d = '0;
        state_d = idx_inc == cnt_q ? FIN : GAP;
      end else fail = timer_q == T_LAST;
      GAP:     state_d = redo_init_q ? INIT : READ;
      default: state_d = IDLE;
    endcase
    if (fail) begin
      redo_init_d = state_q == INIT;
      init_ok_d   = (can_retry && state_q == READ) ? init_ok_q : 1'b0;
      retry_d     = retry_q + 1'b1;
      err_d       = err_q | ~can_retry;
      state_d     = can_retry ? GAP : ERR;
    end
    timer_d = ((state_q == INIT || state_q == READ) && state_d == state_q) ? timer_q + 1'b1 : '0;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      init_ok_q   <= 1'b0;
      redo_init_q <= 1'b0;
      off_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_ok_q   <= init_ok_d;
      redo_init_q <= redo_init_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_sd_seq_ctrl.sv
// tb_sd_seq_ctrl: randomized transactions against a cycle-trace model built from the sequencing rules.
module tb_sd_seq_ctrl;
  localparam int AW = 24, TO = 16, MAXR = 3;

  logic CLK = 0, reset = 1, go = 0, reinit = 0, init_done = 0, read_done = 0;
  logic [15:0] blk_offset = 0;
  logic [7:0]  blk_count = 0;
  logic [31:0] rd_data = 0;
  logic init_start, read_start, data_valid, busy, done_o, error;
  logic [AW-1:0] rd_addr;
  logic [31:0] data_out;
  logic [3:0]  state_dbg;

  always #5 CLK = ~CLK;

  sd_seq_ctrl #(.ADDR_W(AW), .TIMEOUT(TO), .MAX_RETRY(MAXR)) dut (
    .CLK(CLK), .reset(reset), .go(go), .reinit(reinit), .blk_offset(blk_offset), .blk_count(blk_count),
    .init_start(init_start), .init_done(init_done), .read_start(read_start), .read_done(read_done),
    .rd_addr(rd_addr), .rd_data(rd_data), .data_out(data_out), .data_valid(data_valid), .busy(busy),
    .done_o(done_o), .error(error), .state_dbg(state_dbg));

  typedef struct packed {
    logic go, reinit; logic [15:0] off; logic [7:0] cnt; logic idn, rdn; logic [31:0] rdata;
  } stim_t;
  typedef struct packed {
    logic [3:0] st; logic busy, is, rs, dv, dn, er; logic [23:0] addr; logic [31:0] dout;
  } exp_t;

  int tests = 0, fails = 0;
  bit m_init_ok = 0, m_err = 0;
  int m_off = 0, m_idx = 0, m_cnt = 0;
  logic [31:0] m_data = 0;
  int fix_init = -2, fix_read = -2;
  bit fix_data_en = 0;
  logic [31:0] fix_data = 0;
  stim_t sq[$];
  exp_t eq[$];
  logic [23:0] alog[$];
  int init_ent = 0, valid_cnt = 0, done_cnt = 0;
  bit p_is = 0, p_rs = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] maddr();
    longint a;
    a = 64'h200 + (longint'(m_off) + longint'(m_idx)) * 512;
    return a[23:0];
  endfunction

  function automatic exp_t mk(input int st, input bit dv);
    exp_t e;
    e.st = 4'(st); e.busy = st != 0; e.is = st == 1; e.rs = st == 2; e.dv = dv; e.dn = st == 4;
    e.er = m_err; e.addr = maddr(); e.dout = m_data;
    return e;
  endfunction

  function automatic stim_t bstim();
    stim_t s;
    s.go = $urandom_range(0, 5) == 0; s.reinit = 1'($urandom_range(0, 1));
    s.off = 16'($urandom); s.cnt = 8'($urandom); s.idn = 0; s.rdn = 0; s.rdata = $urandom;
    return s;
  endfunction

  function automatic int pick(input bit is_init);
    int f, r;
    f = is_init ? fix_init : fix_read;
    if (f != -2) return f;
    r = $urandom_range(0, 99);
    if (r < 12) return -1;
    if (r < 20) return TO - 1;
    return $urandom_range(0, 4);
  endfunction

  task automatic push(input stim_t s, input exp_t e);
    sq.push_back(s); eq.push_back(e);
  endtask

  task automatic idle(input int n, input bit late_rd);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = bstim(); s.go = 0;
      s.idn = $urandom_range(0, 3) == 0;
      s.rdn = late_rd | ($urandom_range(0, 3) == 0);
      push(s, mk(0, 0));
    end
  endtask

  task automatic phase(input bit is_init, output bit ok, output logic [31:0] dat);
    int d, n;
    stim_t s;
    ok = 0; dat = '0;
    for (int a = 0; a <= MAXR && !ok; a++) begin
      d = pick(is_init);
      n = d < 0 ? TO : d + 1;
      for (int c = 0; c < n; c++) begin
        s = bstim();
        if (is_init) s.rdn = $urandom_range(0, 3) == 0; else s.idn = $urandom_range(0, 3) == 0;
        if (c == d) begin
          if (is_init) s.idn = 1;
          else begin s.rdn = 1; if (fix_data_en) s.rdata = fix_data; dat = s.rdata; end
        end
        push(s, mk(is_init ? 1 : 2, 0));
      end
      if (d >= 0) ok = 1;
      else if (a < MAXR) begin
        if (is_init) m_init_ok = 0;
        push(bstim(), mk(3, 0));
      end
    end
    if (!ok) begin m_err = 1; m_init_ok = 0; push(bstim(), mk(5, 0)); end
  endtask

  task automatic gen_txn(input logic [15:0] off, input logic [7:0] cnt, input bit rin);
    stim_t s;
    bit ok;
    logic [31:0] dat;
    s = bstim(); s.go = 1; s.reinit = rin; s.off = off; s.cnt = cnt; s.idn = 0; s.rdn = 0;
    push(s, mk(0, 0));
    m_err = 0; m_off = off; m_idx = 0; m_cnt = cnt == 0 ? 256 : cnt;
    if (!m_init_ok || rin) begin
      phase(1, ok, dat);
      if (!ok) return;
      m_init_ok = 1;
    end
    for (int i = 0; i < m_cnt; i++) begin
      phase(0, ok, dat);
      if (!ok) return;
      m_data = dat; m_idx++;
      push(bstim(), mk(m_idx == m_cnt ? 4 : 3, 1));
    end
  endtask

  task automatic drive(input stim_t s);
    go = s.go; reinit = s.reinit; blk_offset = s.off; blk_count = s.cnt;
    init_done = s.idn; read_done = s.rdn; rd_data = s.rdata;
  endtask

  task automatic clear_log();
    alog.delete(); init_ent = 0; valid_cnt = 0; done_cnt = 0;
  endtask

  task automatic run_q();
    stim_t s;
    exp_t e, a;
    while (sq.size() > 0) begin
      s = sq.pop_front(); e = eq.pop_front();
      @(negedge CLK);
      a.st = state_dbg; a.busy = busy; a.is = init_start; a.rs = read_start; a.dv = data_valid;
      a.dn = done_o; a.er = error; a.addr = rd_addr; a.dout = data_out;
      chk("cycle", a, e);
      if (init_start && !p_is) init_ent++;
      if (read_start && !p_rs) alog.push_back(rd_addr);
      p_is = init_start; p_rs = read_start;
      valid_cnt += int'(data_valid); done_cnt += int'(done_o);
      drive(s);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_state"}, state_dbg, 4'd0);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_starts"}, {init_start, read_start}, 2'b00);
    chk({nm, "_addr"}, rd_addr, 24'h000200);
    chk({nm, "_data"}, data_out, 32'h0);
    chk({nm, "_strobes"}, {data_valid, done_o, error}, 3'b000);
  endtask

  initial begin
    stim_t s;
    int c;
    #12;
    chk_reset_vals("reset");
    @(negedge CLK); reset = 0;

    fix_init = 10; fix_read = 3; fix_data_en = 1; fix_data = 32'hDEADBEEF;
    clear_log(); idle(2, 0); gen_txn(16'd0, 8'd1, 0); run_q();
    chk("r25_nread", alog.size(), 1);
    if (alog.size() > 0) chk("r25_addr", alog[0], 24'h000200);
    chk("r25_valid", valid_cnt, 1);
    chk("r25_done", done_cnt, 1);
    chk("r25_data", data_out, 32'hDEADBEEF);
    fix_data_en = 0;

    fix_read = 1;
    clear_log(); idle(1, 0); gen_txn(16'd3, 8'd2, 0); run_q();
    chk("r26_init", init_ent, 0);
    chk("r26_nread", alog.size(), 2);
    if (alog.size() > 1) chk("r26_addrs", {alog[0], alog[1]}, {24'h000800, 24'h000A00});
    chk("r26_done", done_cnt, 1);

    fix_read = 0;
    clear_log(); idle(1, 0); gen_txn(16'hFFFF, 8'd2, 0); run_q();
    chk("r28_nread", alog.size(), 2);
    if (alog.size() > 1) chk("r28_addrs", {alog[0], alog[1]}, {24'h000000, 24'h000200});
    chk("r28_err", {error, done_cnt[1:0]}, 3'b001);

    s = bstim(); s.go = 1; s.reinit = 0; s.off = 16'd5; s.cnt = 8'd3; s.idn = 0; s.rdn = 0;
    push(s, mk(0, 0));
    m_err = 0; m_off = 5; m_idx = 0;
    for (int i = 0; i < 3; i++) begin s = bstim(); s.rdn = 0; push(s, mk(2, 0)); end
    run_q();
    #2 reset = 1; go = 0; init_done = 0; read_done = 1;
    #1 chk_reset_vals("r29");
    @(negedge CLK); reset = 0;
    m_init_ok = 0; m_err = 0; m_off = 0; m_idx = 0; m_data = 0;
    clear_log(); idle(3, 1); run_q();
    chk("r29_late", {valid_cnt, done_cnt}, 64'd0);

    fix_init = -1;
    clear_log(); gen_txn(16'd9, 8'd1, 1); idle(1, 0); run_q();
    chk("r27_attempts", init_ent, 4);
    chk("r27_flags", {error, busy}, 2'b10);

    fix_init = 1; fix_read = -1;
    clear_log(); gen_txn(16'd7, 8'd1, 0); idle(1, 0); run_q();
    chk("rdfail_reads", alog.size(), 4);
    chk("rdfail_flags", {error, busy, valid_cnt[0]}, 3'b100);

    fix_init = -2; fix_read = -2;
    for (int t = 0; t < 40; t++) begin
      c = $urandom_range(0, 9);
      idle($urandom_range(0, 2), 0);
      gen_txn(16'($urandom), c == 0 ? 8'd0 : (c < 8 ? 8'($urandom_range(1, 4)) : 8'($urandom_range(5, 20))),
              $urandom_range(0, 4) == 0);
      run_q();
    end
    idle(2, 0); run_q();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
